// File: rtl/quad_pos_gen_if.sv
// Command/status bus of the quadrature encoder emulator.
// master drives commands; slave is the emulator that emits {Z,B,A} and position.
interface quad_pos_gen_if #(
    parameter int DIV_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_zero;
    logic [31:0]      cmd_target;
    logic [DIV_W-1:0] half_period;
    logic             abort;
    logic [2:0]       rot_out;
    logic [31:0]      pos_out;
    logic             busy;
    logic             done;

    modport master (
        output cmd_valid, cmd_zero, cmd_target, half_period, abort,
        input  cmd_ready, rot_out, pos_out, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_zero, cmd_target, half_period, abort,
        output cmd_ready, rot_out, pos_out, busy, done
    );
endinterface

// File: rtl/quad_pos_gen.sv
// Quadrature encoder emulator: turns absolute move commands into A/B steps at a
// programmable rate and zero requests into a Z strobe on a {Z,B,A} bus.
module quad_pos_gen #(
    parameter int DIV_W    = 16,
    parameter int ZERO_CYC = 4
) (
    input  logic          clk,
    input  logic          arstn,
    quad_pos_gen_if.slave bus
);
    localparam int ZW = $clog2(ZERO_CYC + 1);

    typedef enum logic [1:0] {IDLE, STEP, ZERO} state_t;

    state_t           state;
    logic [2:0]       rot;
    logic [31:0]      pos;
    logic [31:0]      target;
    logic             done_r;
    logic [DIV_W-1:0] divider;
    logic [DIV_W-1:0] period;
    logic [ZW-1:0]    zcnt;

    logic             fwd;
    logic [31:0]      pos_nxt;
    logic [1:0]       ab;
    logic [1:0]       ab_nxt;
    logic [DIV_W-1:0] hp_eff;

    always_comb begin
        // Shortest-way direction: upper half of the modular difference is reverse.
        fwd     = ((target - pos) < 32'h8000_0000);
        pos_nxt = fwd ? pos + 32'd1 : pos - 32'd1;
        ab      = {rot[0], rot[1]};
        ab_nxt  = ab;
        if (fwd) begin
            case (ab)
                2'b00:   ab_nxt = 2'b10;
                2'b10:   ab_nxt = 2'b11;
                2'b11:   ab_nxt = 2'b01;
                default: ab_nxt = 2'b00;
            endcase
        end else begin
            case (ab)
                2'b00:   ab_nxt = 2'b01;
                2'b01:   ab_nxt = 2'b11;
                2'b11:   ab_nxt = 2'b10;
                default: ab_nxt = 2'b00;
            endcase
        end
        hp_eff = (bus.half_period == '0) ? DIV_W'(1) : bus.half_period;
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state   <= IDLE;
            rot     <= '0;
            pos     <= '0;
            target  <= '0;
            done_r  <= 1'b0;
            divider <= '0;
            period  <= '0;
            zcnt    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        if (bus.cmd_zero) begin
                            state  <= ZERO;
                            zcnt   <= ZW'(ZERO_CYC);
                            rot[2] <= 1'b1;
                            pos    <= '0;
                        end else if (bus.cmd_target == pos) begin
                            done_r <= 1'b1;
                        end else begin
                            target  <= bus.cmd_target;
                            period  <= hp_eff;
                            divider <= hp_eff;
                            state   <= STEP;
                        end
                    end
                end
                STEP: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (divider == DIV_W'(1)) begin
                        divider  <= period;
                        pos      <= pos_nxt;
                        rot[1:0] <= {ab_nxt[0], ab_nxt[1]};
                        if (pos_nxt == target) begin
                            state  <= IDLE;
                            done_r <= 1'b1;
                        end
                    end else begin
                        divider <= divider - DIV_W'(1);
                    end
                end
                ZERO: begin
                    if (zcnt == ZW'(1)) begin
                        rot[2] <= 1'b0;
                        state  <= IDLE;
                        done_r <= 1'b1;
                    end else begin
                        zcnt <= zcnt - ZW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.rot_out   = rot;
    assign bus.pos_out   = pos;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_quad_pos_gen.sv
// Self-checking bench for quad_pos_gen: directed scenarios plus randomized moves
// checked against a step-count model of position and quadrature phase.
module tb_quad_pos_gen;
    localparam int DIV_W    = 16;
    localparam int ZERO_CYC = 4;

    logic clk = 1'b0;
    logic arstn;
    always #5 clk = ~clk;

    quad_pos_gen_if #(.DIV_W(DIV_W)) bus ();

    quad_pos_gen #(.DIV_W(DIV_W), .ZERO_CYC(ZERO_CYC)) dut (
        .clk  (clk),
        .arstn(arstn),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Model state: emitted position and index into the forward {A,B} cycle.
    logic [31:0] m_pos;
    int          m_ph;
    logic [1:0]  ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    function automatic logic [2:0] mk_rot(input logic z, input int idx);
        logic [1:0] ab;
        ab = ab_tab[idx & 3];
        return {z, ab[0], ab[1]};
    endfunction

    task automatic test_reset();
        arstn = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_zero = 1'b0; bus.cmd_target = '0;
        bus.half_period = '0; bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        checks++; if (bus.rot_out !== 3'b000) begin errors++; $display("FAIL reset_rot got=%b exp=000", bus.rot_out); end
        checks++; if (bus.pos_out !== 32'd0) begin errors++; $display("FAIL reset_pos got=%h exp=0", bus.pos_out); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready); end
        m_pos = '0;
        m_ph  = 0;
    endtask

    task automatic test_forward();
        logic [2:0] fwd_rot [6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b000, 3'b001};
        int k;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_zero = 1'b0; bus.cmd_target = 32'd5; bus.half_period = 16'd3;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL fwd_accept busy=%b ready=%b exp busy=1 ready=0", bus.busy, bus.cmd_ready); end
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            k = (c / 3 > 5) ? 5 : c / 3;
            checks++; if (bus.rot_out !== fwd_rot[k]) begin errors++; $display("FAIL fwd_rot c=%0d got=%b exp=%b", c, bus.rot_out, fwd_rot[k]); end
            checks++; if (bus.pos_out !== 32'(k)) begin errors++; $display("FAIL fwd_pos c=%0d got=%0d exp=%0d", c, bus.pos_out, k); end
            checks++; if (bus.done !== (c == 15)) begin errors++; $display("FAIL fwd_done c=%0d got=%b exp=%b", c, bus.done, c == 15); end
            checks++; if (bus.busy !== (c < 15)) begin errors++; $display("FAIL fwd_busy c=%0d got=%b exp=%b", c, bus.busy, c < 15); end
        end
        m_pos = 32'd5;
        m_ph  = 1;
    endtask

    task automatic test_reverse();
        logic [2:0]  rev_rot [4] = '{3'b001, 3'b000, 3'b010, 3'b011};
        logic [31:0] rev_pos [4] = '{32'd5, 32'd4, 32'd3, 32'd2};
        int k;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_zero = 1'b0; bus.cmd_target = 32'd2; bus.half_period = 16'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            k = (c > 3) ? 3 : c;
            checks++; if (bus.rot_out !== rev_rot[k]) begin errors++; $display("FAIL rev_rot c=%0d got=%b exp=%b", c, bus.rot_out, rev_rot[k]); end
            checks++; if (bus.pos_out !== rev_pos[k]) begin errors++; $display("FAIL rev_pos c=%0d got=%0d exp=%0d", c, bus.pos_out, rev_pos[k]); end
            checks++; if (bus.done !== (c == 3)) begin errors++; $display("FAIL rev_done c=%0d got=%b exp=%b", c, bus.done, c == 3); end
        end
        m_pos = 32'd2;
        m_ph  = 2;
    endtask

    task automatic test_zero();
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_zero = 1'b1; bus.cmd_target = $urandom;
        bus.half_period = DIV_W'($urandom_range(0, 7));
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cmd_zero = 1'b0;
        for (int c = 0; c <= ZERO_CYC + 1; c++) begin
            if (c > 0) begin
                bus.abort = (c == 2);
                @(negedge clk);
                bus.abort = 1'b0;
            end
            checks++; if (bus.rot_out !== mk_rot(c < ZERO_CYC, m_ph)) begin errors++; $display("FAIL zero_rot c=%0d got=%b exp=%b", c, bus.rot_out, mk_rot(c < ZERO_CYC, m_ph)); end
            checks++; if (bus.pos_out !== 32'd0) begin errors++; $display("FAIL zero_pos c=%0d got=%h exp=0", c, bus.pos_out); end
            checks++; if (bus.done !== (c == ZERO_CYC)) begin errors++; $display("FAIL zero_done c=%0d got=%b exp=%b", c, bus.done, c == ZERO_CYC); end
            checks++; if (bus.busy !== (c < ZERO_CYC)) begin errors++; $display("FAIL zero_busy c=%0d got=%b exp=%b", c, bus.busy, c < ZERO_CYC); end
        end
        m_pos = '0;
    endtask

    task automatic test_wrap();
        logic [31:0] wrap_pos [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_zero = 1'b0; bus.cmd_target = 32'hFFFF_FFFE; bus.half_period = '0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++; if (bus.pos_out !== wrap_pos[c-1]) begin errors++; $display("FAIL wrap_pos c=%0d got=%h exp=%h", c, bus.pos_out, wrap_pos[c-1]); end
            checks++; if (bus.rot_out !== mk_rot(1'b0, m_ph - ((c > 2) ? 2 : c))) begin errors++; $display("FAIL wrap_rot c=%0d got=%b", c, bus.rot_out); end
            checks++; if (bus.done !== (c == 2)) begin errors++; $display("FAIL wrap_done c=%0d got=%b exp=%b", c, bus.done, c == 2); end
        end
        m_pos = 32'hFFFF_FFFE;
        m_ph  = (m_ph - 2) & 3;
    endtask

    // Issue one move and follow it cycle by cycle; abort_at=c raises abort before edge c.
    task automatic move_check(input logic [31:0] tgt, input logic [DIV_W-1:0] hp, input int abort_at);
        int p, total, endc, eff, steps, idx;
        longint nsteps;
        logic [31:0] diff, exp_pos;
        bit fwd, abort_hit, exp_done;
        logic [2:0] prev;
        p         = (hp == '0) ? 1 : int'(hp);
        diff      = tgt - m_pos;
        fwd       = (diff[31] == 1'b0);
        nsteps    = fwd ? longint'(diff) : (64'sh1_0000_0000 - longint'(diff));
        total     = int'(nsteps) * p;
        abort_hit = (abort_at > 0) && (abort_at <= total);
        endc      = abort_hit ? abort_at : total;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_zero = 1'b0; bus.cmd_target = tgt; bus.half_period = hp;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checks++; if (bus.busy !== (total != 0)) begin errors++; $display("FAIL mv_accept_busy got=%b exp=%b", bus.busy, total != 0); end
        checks++; if (bus.done !== (total == 0)) begin errors++; $display("FAIL mv_accept_done got=%b exp=%b", bus.done, total == 0); end
        prev = bus.rot_out;
        for (int c = 1; c <= endc + 1; c++) begin
            bus.abort = (c == abort_at);
            if (c < endc && (c == 5 || $urandom_range(0, 7) == 0)) begin
                bus.cmd_valid = 1'b1; bus.cmd_zero = 1'($urandom_range(0, 1)); bus.cmd_target = $urandom;
            end
            @(negedge clk);
            bus.abort = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_zero = 1'b0;
            eff      = (abort_hit && c >= abort_at) ? abort_at - 1 : c;
            steps    = (longint'(eff / p) > nsteps) ? int'(nsteps) : eff / p;
            exp_pos  = fwd ? m_pos + 32'(steps) : m_pos - 32'(steps);
            idx      = fwd ? m_ph + steps : m_ph - steps;
            exp_done = !abort_hit && (c == total);
            checks++; if (bus.pos_out !== exp_pos) begin errors++; $display("FAIL mv_pos c=%0d got=%h exp=%h", c, bus.pos_out, exp_pos); end
            checks++; if (bus.rot_out !== mk_rot(1'b0, idx)) begin errors++; $display("FAIL mv_rot c=%0d got=%b exp=%b", c, bus.rot_out, mk_rot(1'b0, idx)); end
            checks++; if (bus.done !== exp_done) begin errors++; $display("FAIL mv_done c=%0d got=%b exp=%b", c, bus.done, exp_done); end
            checks++; if (bus.busy !== (c < endc)) begin errors++; $display("FAIL mv_busy c=%0d got=%b exp=%b", c, bus.busy, c < endc); end
            checks++; if (bus.cmd_ready !== (c >= endc)) begin errors++; $display("FAIL mv_ready c=%0d got=%b exp=%b", c, bus.cmd_ready, c >= endc); end
            checks++; if ($countones(prev[1:0] ^ bus.rot_out[1:0]) > 1) begin errors++; $display("FAIL mv_ab_both c=%0d prev=%b now=%b exp at most one of A/B changed", c, prev, bus.rot_out); end
            prev = bus.rot_out;
            if (c == endc + 1) begin
                m_pos = exp_pos;
                m_ph  = idx & 3;
            end
        end
    endtask

    task automatic test_abort();
        move_check(32'd1000, DIV_W'(2), 22);
        checks++; if (bus.pos_out !== 32'd10) begin errors++; $display("FAIL abort_pos got=%0d exp=10", bus.pos_out); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", bus.cmd_ready); end
    endtask

    task automatic test_random();
        int delta, abort_at;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                test_zero();
            end else begin
                delta    = int'($urandom_range(0, 24)) - 12;
                abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
                move_check(m_pos + 32'(delta), DIV_W'($urandom_range(0, 4)), abort_at);
            end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_zero = 1'b0; bus.cmd_target = m_pos + 32'd50; bus.half_period = 16'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (7) @(negedge clk);
        arstn = 1'b0;
        @(negedge clk);
        checks++; if (bus.rot_out !== 3'b000) begin errors++; $display("FAIL mrst_rot got=%b exp=000", bus.rot_out); end
        checks++; if (bus.pos_out !== 32'd0) begin errors++; $display("FAIL mrst_pos got=%h exp=0", bus.pos_out); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got=%b exp=0", bus.busy); end
        arstn = 1'b1;
        m_pos = '0;
        m_ph  = 0;
        move_check(32'd3, DIV_W'(1), 0);
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_zero();
        test_wrap();
        test_zero();
        test_abort();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/quad_pos_gen.md
Name: quad_pos_gen

Overview:
Quadrature encoder emulator: the transmit side of the elevation-encoder interface. It drives a 3-bit {Z, B, A} bus with the same format the position counter consumes. Commanded moves become A/B quadrature steps at a programmable rate, and a zero request becomes a Z strobe. The block is used for bench/HIL stimulus of the position readout chain and as a loopback source in the FPGA.

Parameters:
DIV_W, 16, width of the step-period divider and of the half_period input
ZERO_CYC, 4, number of cycles rot_out[2] (Z) is held high for a zero request (minimum 1)

Ports:
clk  input  1  clock
arstn  input  1  reset, synchronous, active-low
cmd_valid  input  1  command strobe; accepted on a cycle where cmd_valid & cmd_ready
cmd_ready  output  1  high when state==IDLE
cmd_zero  input  1  with cmd_valid: issue a zero strobe instead of a move
cmd_target  input  32  absolute target position for a move command
half_period  input  DIV_W  cycles between successive A/B transitions, sampled at accept; 0 treated as 1
abort  input  1  terminate an active move
rot_out  output  3  {Z, B, A}, registered
pos_out  output  32  emitted position (net steps since last zero), registered
busy  output  1  high in STEP or ZERO
done  output  1  one-cycle pulse on command completion

Behaviour:
- Reset (arstn low at a clk edge):
  - state=IDLE, rot_out=3'b000, pos_out=0, done=0, divider=0.
  - cmd_ready reads 1 after the reset edge.
- Quadrature phase {A,B}:
  - Forward sequence (+1 per step): 00 -> 10 -> 11 -> 01 -> 00 (A leads B).
  - Reverse is the exact inverse of the forward sequence.
  - Exactly one of A/B changes per step. A and B never change in the same cycle.
- FSM: IDLE, STEP, ZERO.
- IDLE:
  - cmd_ready=1. No outputs change except done deassertion.
  - On accept with cmd_zero=1: go to ZERO; load zcnt=ZERO_CYC. Next edge: rot_out[2]=1 and pos_out=0.
  - On accept with cmd_zero=0 and cmd_target==pos_out: stay IDLE; done=1 next cycle; no edges emitted.
  - Otherwise: latch target and P=max(half_period,1); load divider=P; go to STEP.
- STEP:
  - Divider decrements each cycle.
  - When divider==1: take one step and reload divider=P.
  - Direction: diff=target-pos_out mod 2^32. diff[31]==0 means forward (pos_out+1), else reverse (pos_out-1).
  - 32-bit arithmetic wraps, no saturation. diff=0x8000_0000 is reverse.
  - Step timing: first step P cycles after the accept edge; subsequent steps every P cycles.
  - rot_out[1:0] and pos_out update on the same edge.
  - If the step makes pos_out==target: same edge go to IDLE and done=1 for one cycle.
  - abort=1 in STEP: next edge go to IDLE. abort wins over a coincident step (no edge emitted). done not asserted. pos_out keeps the last emitted value.
- ZERO:
  - rot_out[2]=1 for exactly ZERO_CYC cycles; A/B held; pos_out=0.
  - abort is ignored.
  - After ZERO_CYC cycles: rot_out[2]=0, go to IDLE, done=1 for one cycle.
- cmd_valid while busy: ignored, not queued.
- Mid-operation reset: immediately returns to reset values, including A/B=00 (the receiver may see one step glitch; accepted).
- Inputs are assumed synchronous to clk; no internal synchronizers.

Test Plan:
1. Hold arstn low 3 cycles, release -> rot_out=000, pos_out=0, busy=0, done=0, cmd_ready=1.
2. From 0, cmd_target=5, half_period=3 -> {A,B} = 10,11,01,00,10 at +3,+6,+9,+12,+15 cycles after accept. pos_out=1..5. done pulses with the 5th step. busy falls the same edge.
3. From 5, cmd_target=2, half_period=1 -> {A,B} = 00,01,11 on consecutive cycles; pos_out=4,3,2; done once.
4. At pos_out=2, cmd_zero=1 -> rot_out[2] high exactly 4 cycles with A/B frozen. pos_out=0 on the first Z cycle. done after Z falls.
5. From 0, cmd_target=0xFFFF_FFFE, half_period=0 -> two reverse steps, one per cycle; pos_out=0xFFFF_FFFF then 0xFFFF_FFFE.
6. cmd_target=1000, half_period=2; abort after 10 steps, coincident with a step edge -> no 11th edge. pos_out=10, done never asserted, cmd_ready=1 next cycle. A cmd_valid issued mid-move is ignored.
